stack_sequencer: RTL and testbench
==================================

STACK_SEQUENCER -- requirements
Module: stack_sequencer

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, width of TOS address and depth logic.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-004 op_valid  input  1  requester presents an operation.
REQ-005 op_code  input  3  000 NOP, 001 PUSH_ALU, 010 PUSH_MEM, 011 POP_MEM, 100 POP, 101 DUP, 110 RET, 111 NOP.
REQ-006 ret_depth  input  ADDR_WIDTH  element count restored by RET.
REQ-007 op_ready  output  1  high only in IDLE.
REQ-008 op_done  output  1  one-cycle pulse in final cycle of a sequence.
REQ-009 err_overflow, err_underflow  output  1 each  one-cycle pulses on a rejected op.
REQ-010 depth  output  ADDR_WIDTH+1  current element count.
REQ-011 SEL_MUX_STACK  output  3; SEL_MUX_TOS, CTRL_REG_TOS, SEL_TOS_UPDATER, CTRL_REG_READ_STACK, CTRL_REG_WRITE_STACK, CTRL_REG_READ_MEM, CTRL_REG_WRITE_MEM, CTRL_STACK, CTRL_MEM_EXT  output  1 each  drive the stack/TOS datapath.

Function
REQ-012 Accept on op_valid && op_ready; op_code and ret_depth sampled at acceptance only.
REQ-013 Control outputs SHALL decode from the state register only (Moore); no combinational path from op inputs to any output.
REQ-014 States: IDLE, INC, WR, DEC, RD, XFER, MWR, MRD, LDTOS, ERR.
REQ-015 In every state, controls not listed are 0; SEL_MUX_STACK is 000 unless listed.
REQ-016 INC: CTRL_REG_TOS=1, SEL_MUX_TOS=0, SEL_TOS_UPDATER=0, CTRL_REG_WRITE_STACK=1, SEL_MUX_STACK per op (PUSH_ALU 000, PUSH_MEM 001, DUP 100).
REQ-017 WR: CTRL_STACK=1. DEC and MWR: CTRL_REG_TOS=1, SEL_TOS_UPDATER=1; MWR also CTRL_MEM_EXT=1.
REQ-018 RD: CTRL_REG_READ_STACK=1. XFER: CTRL_REG_WRITE_MEM=1. MRD: CTRL_REG_READ_MEM=1. LDTOS: CTRL_REG_TOS=1, SEL_MUX_TOS=1.
REQ-019 Sequences: PUSH_ALU INC->WR; PUSH_MEM MRD->INC->WR; DUP RD->INC->WR; POP_MEM RD->XFER->MWR; POP DEC; RET LDTOS; all return to IDLE.
REQ-020 op_done asserts during the last state of each sequence; NOP is accepted, stays IDLE, pulses op_done next cycle via ERR-free one-cycle path (no controls).
REQ-021 Capacity is 2**ADDR_WIDTH-1 elements (address 0 never written).
REQ-022 depth +1 at exit of WR, -1 at exit of DEC or MWR, := ret_depth at exit of LDTOS.
REQ-023 Push-class op (PUSH_ALU, PUSH_MEM, DUP) with depth at capacity SHALL enter ERR: err_overflow=1, op_done=1, no controls, depth unchanged.
REQ-024 POP, POP_MEM or DUP with depth 0 SHALL enter ERR with err_underflow=1, op_done=1; DUP-empty is underflow, not overflow.
REQ-025 ERR lasts exactly one cycle then IDLE; op_ready=0 in ERR.
REQ-026 depth never wraps; RET with ret_depth > capacity loads capacity and pulses err_overflow.

Reset
REQ-027 reset=0 asynchronously forces IDLE, depth=0, all controls 0, op_done/err 0, op_ready=1 once state is IDLE.
REQ-028 Reset mid-sequence abandons it with no further control pulses; datapath TOS register is reset by its own block.
REQ-029 Reset release is synchronised so the first post-reset state change occurs on a clean clk edge.

Structure
REQ-030 Shared package SHALL hold op_code encodings, SEL_MUX_STACK encodings (000 ALU, 001 MEM, 010 RET DATA, 011 ARG, 100 STACK READ) and state enumeration.
REQ-031 Single flat module; no sub-modules; one state register plus depth counter.

Verification
REQ-032 After reset, PUSH_ALU -> cycle+1 INC controls, cycle+2 CTRL_STACK=1 and op_done, depth=1.
REQ-033 PUSH_ALU then POP_MEM -> RD, XFER, MWR asserted on three consecutive cycles, CTRL_MEM_EXT only in MWR, depth 1->0.
REQ-034 POP at depth 0 -> err_underflow one cycle, all controls 0, depth stays 0, op_ready back to 1 after 2 cycles.
REQ-035 ADDR_WIDTH=3, 7 pushes then PUSH_ALU -> err_overflow, depth=7, CTRL_STACK never asserted for 8th.
REQ-036 RET with ret_depth=5 -> LDTOS: CTRL_REG_TOS=1, SEL_MUX_TOS=1, depth=5; reset asserted during PUSH_MEM MRD -> all controls 0 immediately, depth=0.

Source files
------------

// File: rtl/stack_sequencer_pkg.sv
// Shared encodings for the stack sequencer: op codes, stack-input mux selects
// and the sequencer state enumeration.
package stack_sequencer_pkg;

  typedef enum logic [2:0] {
    OP_NOP      = 3'b000,
    OP_PUSH_ALU = 3'b001,
    OP_PUSH_MEM = 3'b010,
    OP_POP_MEM  = 3'b011,
    OP_POP      = 3'b100,
    OP_DUP      = 3'b101,
    OP_RET      = 3'b110,
    OP_NOP_ALT  = 3'b111
  } op_e;

  localparam logic [2:0] SMS_ALU      = 3'b000;
  localparam logic [2:0] SMS_MEM      = 3'b001;
  localparam logic [2:0] SMS_RET_DATA = 3'b010;
  localparam logic [2:0] SMS_ARG      = 3'b011;
  localparam logic [2:0] SMS_STACK_RD = 3'b100;

  typedef enum logic [3:0] {
    S_IDLE, S_INC, S_WR, S_DEC, S_RD, S_XFER, S_MWR, S_MRD, S_LDTOS, S_ERR
  } state_e;

  function automatic logic is_push(op_e op);
    return (op == OP_PUSH_ALU) || (op == OP_PUSH_MEM) || (op == OP_DUP);
  endfunction

endpackage

// File: rtl/stack_sequencer_if.sv
// Operation handshake plus the datapath control bundle of the stack sequencer.
interface stack_sequencer_if #(parameter int ADDR_WIDTH = 12);
  logic                  op_valid;
  logic [2:0]            op_code;
  logic [ADDR_WIDTH-1:0] ret_depth;
  logic                  op_ready;
  logic                  op_done;
  logic                  err_overflow;
  logic                  err_underflow;
  logic [ADDR_WIDTH:0]   depth;
  logic [2:0]            SEL_MUX_STACK;
  logic                  SEL_MUX_TOS;
  logic                  CTRL_REG_TOS;
  logic                  SEL_TOS_UPDATER;
  logic                  CTRL_REG_READ_STACK;
  logic                  CTRL_REG_WRITE_STACK;
  logic                  CTRL_REG_READ_MEM;
  logic                  CTRL_REG_WRITE_MEM;
  logic                  CTRL_STACK;
  logic                  CTRL_MEM_EXT;

  modport master (
    output op_valid, op_code, ret_depth,
    input  op_ready, op_done, err_overflow, err_underflow, depth,
           SEL_MUX_STACK, SEL_MUX_TOS, CTRL_REG_TOS, SEL_TOS_UPDATER,
           CTRL_REG_READ_STACK, CTRL_REG_WRITE_STACK, CTRL_REG_READ_MEM,
           CTRL_REG_WRITE_MEM, CTRL_STACK, CTRL_MEM_EXT
  );

  modport slave (
    input  op_valid, op_code, ret_depth,
    output op_ready, op_done, err_overflow, err_underflow, depth,
           SEL_MUX_STACK, SEL_MUX_TOS, CTRL_REG_TOS, SEL_TOS_UPDATER,
           CTRL_REG_READ_STACK, CTRL_REG_WRITE_STACK, CTRL_REG_READ_MEM,
           CTRL_REG_WRITE_MEM, CTRL_STACK, CTRL_MEM_EXT
  );
endinterface

// File: rtl/stack_sequencer.sv
// Moore sequencer that expands stack operations into per-cycle control words
// for the stack/TOS datapath and tracks the element count.
module stack_sequencer
  import stack_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic clk,
  input  logic reset,
  stack_sequencer_if.slave bus
);

  // Address 0 is never written, so one slot of the address space is unusable.
  localparam logic [ADDR_WIDTH:0] CAP = {1'b0, {ADDR_WIDTH{1'b1}}};

  logic [1:0] rst_sync_q;
  logic       rst_n;

  // Assert immediately, release only after two clean clock edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  state_e                state_q, state_d;
  op_e                   op_q, op_d;
  logic [ADDR_WIDTH-1:0] ret_q, ret_d;
  logic [ADDR_WIDTH:0]   depth_q, depth_d;
  logic                  err_ovf_q, err_ovf_d;
  logic                  nop_done_q, nop_done_d;
  logic                  accept, full, empty;
  op_e                   op_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= OP_NOP;
      ret_q      <= '0;
      depth_q    <= '0;
      err_ovf_q  <= 1'b0;
      nop_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      ret_q      <= ret_d;
      depth_q    <= depth_d;
      err_ovf_q  <= err_ovf_d;
      nop_done_q <= nop_done_d;
    end
  end

  assign op_in  = op_e'(bus.op_code);
  assign accept = bus.op_valid && bus.op_ready;
  assign full   = (depth_q == CAP);
  assign empty  = (depth_q == '0);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    ret_d      = ret_q;
    depth_d    = depth_q;
    err_ovf_d  = err_ovf_q;
    nop_done_d = 1'b0;
    unique case (state_q)
      S_IDLE: if (accept) begin
        op_d  = op_in;
        ret_d = bus.ret_depth;
        // Underflow takes priority so DUP on an empty stack is never an overflow.
        if (empty && (op_in == OP_POP || op_in == OP_POP_MEM || op_in == OP_DUP)) begin
          state_d   = S_ERR;
          err_ovf_d = 1'b0;
        end else if (full && is_push(op_in)) begin
          state_d   = S_ERR;
          err_ovf_d = 1'b1;
        end else begin
          unique case (op_in)
            OP_PUSH_ALU:         state_d = S_INC;
            OP_PUSH_MEM:         state_d = S_MRD;
            OP_DUP, OP_POP_MEM:  state_d = S_RD;
            OP_POP:              state_d = S_DEC;
            OP_RET:              state_d = S_LDTOS;
            OP_NOP, OP_NOP_ALT:  nop_done_d = 1'b1;
          endcase
        end
      end
      S_MRD:   state_d = S_INC;
      S_INC:   state_d = S_WR;
      S_RD:    state_d = (op_q == OP_DUP) ? S_INC : S_XFER;
      S_XFER:  state_d = S_MWR;
      S_WR: begin
        state_d = S_IDLE;
        depth_d = depth_q + 1'b1;
      end
      S_DEC, S_MWR: begin
        state_d = S_IDLE;
        depth_d = depth_q - 1'b1;
      end
      S_LDTOS: begin
        state_d = S_IDLE;
        depth_d = {1'b0, ret_q};
      end
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.op_ready             = (state_q == S_IDLE) && rst_n;
    bus.op_done              = nop_done_q;
    bus.err_overflow         = 1'b0;
    bus.err_underflow        = 1'b0;
    bus.depth                = depth_q;
    bus.SEL_MUX_STACK        = SMS_ALU;
    bus.SEL_MUX_TOS          = 1'b0;
    bus.CTRL_REG_TOS         = 1'b0;
    bus.SEL_TOS_UPDATER      = 1'b0;
    bus.CTRL_REG_READ_STACK  = 1'b0;
    bus.CTRL_REG_WRITE_STACK = 1'b0;
    bus.CTRL_REG_READ_MEM    = 1'b0;
    bus.CTRL_REG_WRITE_MEM   = 1'b0;
    bus.CTRL_STACK           = 1'b0;
    bus.CTRL_MEM_EXT         = 1'b0;
    unique case (state_q)
      S_INC: begin
        bus.CTRL_REG_TOS         = 1'b1;
        bus.CTRL_REG_WRITE_STACK = 1'b1;
        bus.SEL_MUX_STACK        = (op_q == OP_PUSH_MEM) ? SMS_MEM :
                                   (op_q == OP_DUP)      ? SMS_STACK_RD : SMS_ALU;
      end
      S_WR: begin
        bus.CTRL_STACK = 1'b1;
        bus.op_done    = 1'b1;
      end
      S_DEC: begin
        bus.CTRL_REG_TOS    = 1'b1;
        bus.SEL_TOS_UPDATER = 1'b1;
        bus.op_done         = 1'b1;
      end
      S_RD:   bus.CTRL_REG_READ_STACK = 1'b1;
      S_XFER: bus.CTRL_REG_WRITE_MEM  = 1'b1;
      S_MWR: begin
        bus.CTRL_REG_TOS    = 1'b1;
        bus.SEL_TOS_UPDATER = 1'b1;
        bus.CTRL_MEM_EXT    = 1'b1;
        bus.op_done         = 1'b1;
      end
      S_MRD:  bus.CTRL_REG_READ_MEM = 1'b1;
      // ret_depth is ADDR_WIDTH bits wide, so it can never exceed capacity.
      S_LDTOS: begin
        bus.CTRL_REG_TOS = 1'b1;
        bus.SEL_MUX_TOS  = 1'b1;
        bus.op_done      = 1'b1;
      end
      S_ERR: begin
        bus.op_done       = 1'b1;
        bus.err_overflow  = err_ovf_q;
        bus.err_underflow = !err_ovf_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_stack_sequencer.sv
// Random and directed check of stack_sequencer against a per-operation
// model that expands each accepted op into its expected per-cycle outputs.
module tb_stack_sequencer;

  localparam int AW  = 3;
  localparam int CAP = 7;

  typedef struct packed {
    logic       ready, done, ovf, unf;
    logic [2:0] sel;
    logic [8:0] ctrl;  // SEL_TOS REG_TOS UPD RD_STK WR_STK RD_MEM WR_MEM STACK MEM_EXT
    logic [3:0] depth;
  } frame_t;

  localparam logic [8:0] K_INC  = 9'b010010000;
  localparam logic [8:0] K_WR   = 9'b000000010;
  localparam logic [8:0] K_DEC  = 9'b011000000;
  localparam logic [8:0] K_MWR  = 9'b011000001;
  localparam logic [8:0] K_RD   = 9'b000100000;
  localparam logic [8:0] K_XFER = 9'b000000100;
  localparam logic [8:0] K_MRD  = 9'b000001000;
  localparam logic [8:0] K_LDT  = 9'b110000000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  stack_sequencer_if #(.ADDR_WIDTH(AW)) bus();
  stack_sequencer #(.ADDR_WIDTH(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

  int     nvec = 0;
  int     nerr = 0;
  int     dm   = 0;
  frame_t q[$];
  frame_t hist[$];

  function automatic frame_t mk(logic r, logic d, logic o, logic u, logic [2:0] s,
                                logic [8:0] c, int dep);
    frame_t f;
    f.ready = r; f.done = d; f.ovf = o; f.unf = u; f.sel = s; f.ctrl = c;
    f.depth = dep[3:0];
    return f;
  endfunction

  function automatic frame_t sample();
    return {bus.op_ready, bus.op_done, bus.err_overflow, bus.err_underflow,
            bus.SEL_MUX_STACK,
            bus.SEL_MUX_TOS, bus.CTRL_REG_TOS, bus.SEL_TOS_UPDATER,
            bus.CTRL_REG_READ_STACK, bus.CTRL_REG_WRITE_STACK,
            bus.CTRL_REG_READ_MEM, bus.CTRL_REG_WRITE_MEM,
            bus.CTRL_STACK, bus.CTRL_MEM_EXT, bus.depth};
  endfunction

  function automatic frame_t h(int i);
    if (i >= 0 && i < hist.size()) return hist[i];
    return '1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected outputs for one accepted op, one frame per cycle, from the op rules.
  task automatic build(input logic [2:0] op, input logic [2:0] rd);
    int d = dm;
    bit full  = (d == CAP);
    bit empty = (d == 0);
    case (op)
      3'd1, 3'd2, 3'd5: begin
        if (op == 3'd5 && empty) q.push_back(mk(0, 1, 0, 1, 0, 0, d));
        else if (full)           q.push_back(mk(0, 1, 1, 0, 0, 0, d));
        else begin
          if (op == 3'd2) q.push_back(mk(0, 0, 0, 0, 0, K_MRD, d));
          if (op == 3'd5) q.push_back(mk(0, 0, 0, 0, 0, K_RD, d));
          q.push_back(mk(0, 0, 0, 0, (op == 3'd1) ? 3'b000 : (op == 3'd2) ? 3'b001 : 3'b100,
                         K_INC, d));
          q.push_back(mk(0, 1, 0, 0, 0, K_WR, d));
          dm = d + 1;
        end
      end
      3'd3: begin
        if (empty) q.push_back(mk(0, 1, 0, 1, 0, 0, d));
        else begin
          q.push_back(mk(0, 0, 0, 0, 0, K_RD, d));
          q.push_back(mk(0, 0, 0, 0, 0, K_XFER, d));
          q.push_back(mk(0, 1, 0, 0, 0, K_MWR, d));
          dm = d - 1;
        end
      end
      3'd4: begin
        if (empty) q.push_back(mk(0, 1, 0, 1, 0, 0, d));
        else begin
          q.push_back(mk(0, 1, 0, 0, 0, K_DEC, d));
          dm = d - 1;
        end
      end
      3'd6: begin
        q.push_back(mk(0, 1, 0, 0, 0, K_LDT, d));
        dm = int'(rd);
      end
      default: q.push_back(mk(1, 1, 0, 0, 0, 0, d));
    endcase
  endtask

  // The single compare point: every cycle, DUT outputs vs the model's frame.
  task automatic cycle(input bit want, input logic [2:0] op, input logic [2:0] rd,
                       output bit acc);
    frame_t e, a;
    @(negedge clk);
    e = (q.size() > 0) ? q.pop_front() : mk(1, 0, 0, 0, 0, 0, dm);
    a = sample();
    hist.push_back(a);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL cycle%0d: got %h expected %h", hist.size() - 1, a, e);
    end
    bus.op_valid  = want;
    bus.op_code   = op;
    bus.ret_depth = rd;
    @(posedge clk);
    acc = want && e.ready;
    if (acc) build(op, rd);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [2:0] rd, output int s);
    bit acc = 0;
    int n = 0;
    while (!acc && n < 20) begin cycle(1, op, rd, acc); n++; end
    if (!acc) begin nvec++; nerr++; $display("FAIL accept_timeout: got 0 expected 1"); end
    s = hist.size();
    n = 0;
    while (q.size() > 0 && n < 20) begin cycle(0, 3'($urandom), 3'($urandom), acc); n++; end
    if (q.size() > 0) begin nvec++; nerr++; $display("FAIL drain_timeout: got %0d expected 0", q.size()); end
    cycle(0, 3'($urandom), 3'($urandom), acc);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1 reset = 1'b0;
    #1 chk("reset_outputs", 32'(sample()), 32'(mk(0, 0, 0, 0, 0, 0, 0)));
    bus.op_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    repeat (3) @(posedge clk);
    q.delete();
    dm = 0;
  endtask

  initial begin
    int  s;
    bit  acc;
    bus.op_valid  = 1'b0;
    bus.op_code   = 3'd0;
    bus.ret_depth = '0;
    do_reset();

    // PUSH_ALU from empty: INC then WR with op_done, depth 1 afterwards.
    run_op(3'd1, 0, s);
    chk("push_inc_ctrl", 32'(h(s).ctrl), 32'h090);
    chk("push_wr_stack", 32'(h(s + 1).ctrl), 32'h002);
    chk("push_wr_done",  32'(h(s + 1).done), 32'd1);
    chk("push_depth",    32'(h(s + 2).depth), 32'd1);

    // POP_MEM: RD, XFER, MWR on consecutive cycles, MEM_EXT only in MWR.
    run_op(3'd3, 0, s);
    chk("popm_rd",   32'(h(s).ctrl), 32'h020);
    chk("popm_xfer", 32'(h(s + 1).ctrl), 32'h004);
    chk("popm_mwr",  32'(h(s + 2).ctrl), 32'h0c1);
    chk("popm_depth_before", 32'(h(s).depth), 32'd1);
    chk("popm_depth_after",  32'(h(s + 3).depth), 32'd0);

    // POP on empty: underflow for one cycle, no controls, ready after.
    run_op(3'd4, 0, s);
    chk("pop_empty_unf",   32'(h(s).unf), 32'd1);
    chk("pop_empty_ctrl",  32'(h(s).ctrl), 32'd0);
    chk("pop_empty_ready", 32'(h(s).ready), 32'd0);
    chk("pop_empty_back",  32'(h(s + 1).ready), 32'd1);
    chk("pop_empty_depth", 32'(h(s + 1).depth), 32'd0);

    // DUP on empty is an underflow.
    run_op(3'd5, 0, s);
    chk("dup_empty_unf", 32'(h(s).unf), 32'd1);
    chk("dup_empty_ovf", 32'(h(s).ovf), 32'd0);

    // RET loads depth.
    run_op(3'd6, 3'd5, s);
    chk("ret_ldtos", 32'(h(s).ctrl), 32'h180);
    chk("ret_depth", 32'(h(s + 1).depth), 32'd5);

    // Fill to capacity, then one more push overflows without touching the stack.
    run_op(3'd1, 0, s);
    run_op(3'd1, 0, s);
    run_op(3'd1, 0, s);
    chk("full_ovf",   32'(h(s).ovf), 32'd1);
    chk("full_ctrl",  32'(h(s).ctrl), 32'd0);
    chk("full_nostk", 32'(h(s + 1).ctrl), 32'd0);
    chk("full_depth", 32'(h(s + 1).depth), 32'd7);
    run_op(3'd5, 0, s);
    chk("dup_full_ovf", 32'(h(s).ovf), 32'd1);

    // Reset during the MRD cycle of PUSH_MEM clears everything at once.
    do_reset();
    cycle(1, 3'd2, 0, acc);
    #1 chk("mrd_active", 32'(bus.CTRL_REG_READ_MEM), 32'd1);
    do_reset();

    for (int i = 0; i < 600; i++)
      cycle(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), acc);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
